// File: rtl/mesh_terminal_endpoint_if.sv
// Bundle of the three handshakes a terminal endpoint sits on:
// local source (tx_*), mesh link in both directions, local sink (rx_*).
//
// Handshake rules:
//   tx_valid/tx_ready : a word moves on a rising edge where both are high.
//   pndng_i_in/popin  : the mesh consumes data_out_i_in on an edge with popin high.
//   pndng/pop         : the endpoint consumes data_out on the edge where it raises pop.
//   rx_valid/rx_ready : a word moves on a rising edge where both are high.
interface mesh_terminal_endpoint_if #(
  parameter int pckg_sz = 40
);
  logic [pckg_sz-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [pckg_sz-1:0] data_out_i_in;
  logic               pndng_i_in;
  logic               popin;
  logic [pckg_sz-1:0] data_out;
  logic               pndng;
  logic               pop;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_valid;
  logic               rx_ready;

  // Endpoint side.
  modport slave (
    input  tx_data, tx_valid, popin, data_out, pndng, rx_ready,
    output tx_ready, data_out_i_in, pndng_i_in, pop, rx_data, rx_valid
  );

  // Environment side: local source/sink and the mesh port.
  modport master (
    output tx_data, tx_valid, popin, data_out, pndng, rx_ready,
    input  tx_ready, data_out_i_in, pndng_i_in, pop, rx_data, rx_valid
  );
endinterface

// File: rtl/mesh_terminal_endpoint.sv
// Terminal-side endpoint for one mesh_gnrtr port.
// TX: show-ahead FIFO from the local source toward the mesh (pndng_i_in/popin).
// RX: a three-state popper (IDLE/POP/GAP) pulls packets off the mesh into a
// show-ahead FIFO toward the local sink, counting packets whose destination
// field is not this terminal.
module mesh_terminal_endpoint #(
  parameter int       pckg_sz    = 40,
  parameter int       fifo_depth = 4,
  parameter bit [3:0] TERM_ROW   = 4'd0,
  parameter bit [3:0] TERM_COL   = 4'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  mesh_terminal_endpoint_if.slave bus,
  output logic [15:0]             misroute_cnt,
  output logic                    tx_underflow,
  output logic [1:0]              rx_state_dbg
);

  localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = $clog2(fifo_depth + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(fifo_depth - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(fifo_depth);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_POP  = 2'd1,
    RX_GAP  = 2'd2
  } rx_state_e;

  // ---------------------------------------------------------------- TX FIFO
  logic [pckg_sz-1:0] tx_mem [fifo_depth];
  logic [AW-1:0]      tx_wr, tx_rd;
  logic [CW-1:0]      tx_cnt;
  logic               tx_empty, tx_full, tx_push, tx_pop;
  logic               rst_done;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == FULL_CNT);
  // tx_ready depends only on registered state, so popin never reaches it.
  assign bus.tx_ready      = rst_done && !tx_full;
  assign tx_push           = bus.tx_valid && bus.tx_ready;
  assign tx_pop            = bus.popin && !tx_empty;
  assign bus.pndng_i_in    = !tx_empty;
  assign bus.data_out_i_in = tx_empty ? '0 : tx_mem[tx_rd];

  // Holds tx_ready low for the first cycle after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  // TX storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.tx_data;
  end

  // TX pointers, occupancy and sticky underflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wr        <= '0;
      tx_rd        <= '0;
      tx_cnt       <= '0;
      tx_underflow <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= (tx_wr == LAST_PTR) ? '0 : tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= (tx_rd == LAST_PTR) ? '0 : tx_rd + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (bus.popin && tx_empty) tx_underflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  rx_state_e          rx_state, rx_next;
  logic               rx_capture;
  logic               pop_q;
  logic [pckg_sz-1:0] rx_mem [fifo_depth];
  logic [AW-1:0]      rx_wr, rx_rd;
  logic [CW-1:0]      rx_cnt;
  logic               rx_empty, rx_full, rx_deq;
  logic               dst_mismatch;

  assign rx_empty     = (rx_cnt == '0);
  assign rx_full      = (rx_cnt == FULL_CNT);
  assign rx_state_dbg = rx_state;

  // RX state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // Next state: capture only with space; GAP gives the mesh a cycle to
  // retire the consumed packet before pndng is sampled again.
  always_comb begin
    rx_next    = rx_state;
    rx_capture = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (bus.pndng && !rx_full) begin
          rx_next    = RX_POP;
          rx_capture = 1'b1;
        end
      end
      RX_POP:  rx_next = RX_GAP;
      RX_GAP:  rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  // pop is a flop set on the capture edge; async reset cuts it off at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pop_q <= 1'b0;
    else        pop_q <= rx_capture;
  end
  assign bus.pop = pop_q;

  // ---------------------------------------------------------------- RX FIFO
  assign bus.rx_valid = !rx_empty;
  assign bus.rx_data  = rx_empty ? '0 : rx_mem[rx_rd];
  assign rx_deq       = bus.rx_valid && bus.rx_ready;

  // RX storage; written on the edge the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    if (rx_capture) rx_mem[rx_wr] <= bus.data_out;
  end

  // RX pointers and occupancy; a dequeue frees space for the next cycle's check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_capture) rx_wr <= (rx_wr == LAST_PTR) ? '0 : rx_wr + AW'(1);
      if (rx_deq)     rx_rd <= (rx_rd == LAST_PTR) ? '0 : rx_rd + AW'(1);
      case ({rx_capture, rx_deq})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // ------------------------------------------------------ destination check
  assign dst_mismatch = (bus.data_out[pckg_sz-9 -: 4]  != TERM_ROW) ||
                        (bus.data_out[pckg_sz-13 -: 4] != TERM_COL);

  // Saturating count of misrouted captures; the packet is still delivered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misroute_cnt <= '0;
    end else if (rx_capture && dst_mismatch && (misroute_cnt != 16'hFFFF)) begin
      misroute_cnt <= misroute_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mesh_terminal_endpoint.sv
// Directed bench for mesh_terminal_endpoint placed at terminal (1,2), depth 4.
module tb_mesh_terminal_endpoint;
  localparam int W = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] misroute_cnt;
  logic        tx_underflow;
  logic [1:0]  rx_state_dbg;
  int          checks = 0;
  int          errors = 0;

  mesh_terminal_endpoint_if #(.pckg_sz(W)) bus ();

  mesh_terminal_endpoint #(
    .pckg_sz(W), .fifo_depth(4), .TERM_ROW(4'd1), .TERM_COL(4'd2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .misroute_cnt(misroute_cnt), .tx_underflow(tx_underflow),
    .rx_state_dbg(rx_state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pkt(input logic [7:0] tag, input logic [3:0] r,
                                       input logic [3:0] c, input logic [23:0] pl);
    return {tag, r, c, pl};
  endfunction

  logic [W-1:0] tx_exp [4];
  int           npk;
  int           waited;
  logic         exp_pop;

  initial begin
    // ---- reset with stimulus pending
    reset          = 1'b0;
    bus.tx_valid   = 1'b1;
    bus.tx_data    = 40'h99;
    bus.popin      = 1'b0;
    bus.pndng      = 1'b1;
    bus.data_out   = pkt(8'hAA, 4'd1, 4'd2, 24'd1);
    bus.rx_ready   = 1'b0;
    step();
    step();
    chk("reset_pop",        bus.pop, 0);
    chk("reset_pndng_i_in", bus.pndng_i_in, 0);
    chk("reset_tx_ready",   bus.tx_ready, 0);
    chk("reset_rx_valid",   bus.rx_valid, 0);
    chk("reset_rx_data",    bus.rx_data, 0);
    chk("reset_tx_head",    bus.data_out_i_in, 0);
    chk("reset_misroute",   misroute_cnt, 0);
    chk("reset_underflow",  tx_underflow, 0);
    chk("reset_state",      rx_state_dbg, 0);
    bus.tx_valid = 1'b0;
    bus.pndng    = 1'b0;
    reset        = 1'b1;
    #1;
    chk("ready_before_edge", bus.tx_ready, 0);
    step();
    chk("ready_after_edge", bus.tx_ready, 1);

    // ---- TX ordering and underflow
    for (int i = 0; i < 3; i++) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = 40'hA1 + W'(i);
      step();
    end
    bus.tx_valid = 1'b0;
    chk("tx_head_a1", bus.data_out_i_in, 40'hA1);
    chk("tx_pndng_on", bus.pndng_i_in, 1);
    bus.popin = 1'b1;
    step();
    chk("tx_head_a2", bus.data_out_i_in, 40'hA2);
    step();
    chk("tx_head_a3", bus.data_out_i_in, 40'hA3);
    step();
    chk("tx_pndng_off", bus.pndng_i_in, 0);
    chk("tx_head_empty", bus.data_out_i_in, 0);
    chk("tx_no_underflow_yet", tx_underflow, 0);
    step();
    chk("tx_underflow_set", tx_underflow, 1);
    bus.popin = 1'b0;

    // ---- TX full: fifth push dropped, then push+pop keeps order
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.tx_data = 40'hB1 + W'(i);
      step();
    end
    bus.tx_valid = 1'b0;
    chk("tx_full_ready", bus.tx_ready, 0);
    chk("tx_full_head_b1", bus.data_out_i_in, 40'hB1);
    bus.popin = 1'b1;
    step();
    chk("tx_pop_head_b2", bus.data_out_i_in, 40'hB2);
    chk("tx_ready_3", bus.tx_ready, 1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 40'hB6;
    step();
    chk("tx_pushpop_head_b3", bus.data_out_i_in, 40'hB3);
    chk("tx_pushpop_ready", bus.tx_ready, 1);
    bus.popin   = 1'b0;
    bus.tx_data = 40'hB7;
    step();
    bus.tx_valid = 1'b0;
    chk("tx_refull_ready", bus.tx_ready, 0);
    tx_exp[0] = 40'hB3;
    tx_exp[1] = 40'hB4;
    tx_exp[2] = 40'hB6;
    tx_exp[3] = 40'hB7;
    bus.popin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tx_drain_%0d", i), bus.data_out_i_in, tx_exp[i]);
      step();
    end
    bus.popin = 1'b0;
    chk("tx_drained", bus.pndng_i_in, 0);

    // ---- RX handshake, spacing and backpressure (rx_ready=0)
    npk          = 0;
    bus.data_out = pkt(8'hC0, 4'd1, 4'd2, 24'd0);
    bus.pndng    = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      exp_pop = (c == 1) || (c == 4) || (c == 7) || (c == 10);
      chk($sformatf("rx_pop_cycle_%0d", c), bus.pop, exp_pop);
      if (bus.pop) begin
        npk++;
        bus.data_out = pkt(8'hC0 + 8'(npk), 4'd1, 4'd2, 24'(npk));
      end
    end
    chk("rx_pop_count", npk, 4);
    chk("rx_misroute_zero", misroute_cnt, 0);
    chk("rx_head_c0", bus.rx_data, pkt(8'hC0, 4'd1, 4'd2, 24'd0));
    chk("rx_valid_full", bus.rx_valid, 1);
    chk("rx_state_idle_full", rx_state_dbg, 0);
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    chk("rx_head_c1", bus.rx_data, pkt(8'hC1, 4'd1, 4'd2, 24'd1));
    waited = 0;
    while (!bus.pop && waited < 10) begin
      step();
      waited++;
    end
    bus.pndng = 1'b0;
    chk("rx_pop_after_free", bus.pop, 1);
    chk("rx_pop_after_free_lat", waited, 1);
    bus.rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("rx_drain_%0d", i), bus.rx_data, pkt(8'hC0 + 8'(i), 4'd1, 4'd2, 24'(i)));
      step();
    end
    bus.rx_ready = 1'b0;
    chk("rx_drained", bus.rx_valid, 0);

    // ---- misrouted packet (3,3) is counted and still delivered
    bus.data_out = pkt(8'hCD, 4'd3, 4'd3, 24'd1);
    bus.pndng    = 1'b1;
    step();
    bus.pndng = 1'b0;
    chk("mis_pop", bus.pop, 1);
    chk("mis_count", misroute_cnt, 1);
    chk("mis_delivered", bus.rx_data, pkt(8'hCD, 4'd3, 4'd3, 24'd1));
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    chk("mis_dequeued", bus.rx_valid, 0);
    chk("mis_count_hold", misroute_cnt, 1);

    // ---- reset while pop is high, with TX holding a packet
    bus.tx_valid = 1'b1;
    bus.tx_data  = 40'hE1;
    step();
    bus.tx_valid = 1'b0;
    chk("pre_reset_tx_pndng", bus.pndng_i_in, 1);
    bus.data_out = pkt(8'hEE, 4'd1, 4'd2, 24'd2);
    bus.pndng    = 1'b1;
    step();
    bus.pndng = 1'b0;
    chk("pre_reset_pop", bus.pop, 1);
    reset = 1'b0;
    #1;
    chk("midreset_pop", bus.pop, 0);
    chk("midreset_rx_valid", bus.rx_valid, 0);
    chk("midreset_tx_pndng", bus.pndng_i_in, 0);
    chk("midreset_tx_ready", bus.tx_ready, 0);
    chk("midreset_misroute", misroute_cnt, 0);
    chk("midreset_underflow", tx_underflow, 0);
    chk("midreset_state", rx_state_dbg, 0);
    step();
    reset = 1'b1;
    step();
    chk("post_reset_ready", bus.tx_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
